m4_frame_checker: RTL
=====================

# m4_frame_checker

Receive-side checker for the M4 telemetry frame stream produced by the imitator's filler. It sits after the word deserializer and takes one 12-bit word plus its 9-bit frame position. It then checks the frame counter, the group counter, the subframe markers and the filler words against the filler's encoding rules. It reports lock status, error counts and the last decoded counters for the test console.

## Interface
- LOCK_FRAMES, 2: consecutive error-free frames needed to move from VERIFY to LOCKED.
- UNLOCK_ERRS, 8: errors within one frame that drop the checker from LOCKED to HUNT.
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- wordValid  in  1  word/pointer/grpNum valid this cycle; may stay high several cycles for the same word.
- wordPtr  in  9  word position in frame, 0..511.
- wordData  in  12  received word.
- grpNum  in  5  group number accompanying the frame.
- locked  out  1  high in LOCKED state.
- errFlag  out  1  one-cycle pulse per detected word error.
- errCount  out  16  total word errors since reset; saturates at 16'hFFFF.
- lastErrPtr  out  9  wordPtr of the most recent error.
- frameCnt  out  10  last frame counter decoded from word 0.
- grpCnt  out  10  last group counter decoded from word 149.

## Operation
- Accept: a word is processed when wordValid=1 and either wordPtr differs from the last processed pointer or it is the first word after reset. Repeats of the same pointer are ignored.
- Word classes and required encoding (bit 11 must be 0 in all classes):
  - Pointer 0, frame word: bit0=1, [10:1]=frame counter. Expected value is prev+1, except prev=500 gives 0.
  - Pointer 149, group word: bit0=0, [10:1]=group counter. Expected value is prev+1 (mod 1024) if grpNum was 0 at the previous word 149, otherwise prev.
  - Pointers 2+16k (k=0..31, i.e. 2..498), marker words: [2:0]=3'b001, [10:3]=subframe counter. Expected value is prev+1 (mod 256), continuous across frames.
  - All other pointers, filler words: must equal 12'h002 (see Configuration).
- Each counter has a seeded flag. On the first occurrence after entering HUNT, the counter is stored without a value check; its format bits are still checked.
- Any format or value mismatch is one error. The received value always replaces the expected-base register, so resync is immediate.
- State machine:
  - HUNT: clear seeded flags and the per-frame error count. Ignore words until pointer 0, then go to VERIFY.
  - VERIFY: on each pointer 0 (frame boundary), if the previous frame had zero errors, increment the good-frame count. When it reaches LOCK_FRAMES, go to LOCKED. Any errored frame resets the good-frame count to 0.
  - LOCKED: when the per-frame error count reaches UNLOCK_ERRS, go to HUNT at the next cycle.
- Errors count toward errCount and pulse errFlag in every state except HUNT.
- frameCnt and grpCnt update on every accepted word 0 and word 149 respectively, including in HUNT.

## Timing
- Reset values: locked=0, errFlag=0, errCount=0, lastErrPtr=0, frameCnt=0, grpCnt=0; state HUNT.
- All outputs are registered; results appear one clk after the accepted word's cycle.
- errFlag is high for exactly one cycle per erroneous accepted word. Back-to-back erroneous words give back-to-back pulses.
- Per-frame error count clears on the same cycle that pointer 0 is accepted. Errors in word 0 itself count toward the new frame.
- Same cycle as UNLOCK_ERRS is reached: the error is still counted, and locked falls on the following edge.
- errCount at 16'hFFFF stays at 16'hFFFF; errFlag still pulses.
- A pointer jump (missing words) is not itself an error. Only the content of received words is checked.
- Asserting reset mid-frame returns to HUNT immediately; no partial-frame state survives.

## Configuration
- M4CHK_FILLER_CHECK_EN defined: filler-class words are compared against 12'h002, and mismatches count as errors.
- Not defined: filler-class words are accepted without checking. Only the frame word, group word and marker words are checked, and the comparator logic is removed.

## Test plan
- Clean stream: frames with frame counter 0,1,2,…, markers incrementing, grpNum=0 every frame -> locked=1 one cycle after the pointer 0 of the third frame; errCount=0.
- Frame-counter wrap: frames carrying 499,500,0,1 -> no errors; frameCnt reads 0 after the third frame's word 0.
- Corrupt marker at pointer 34 ([2:0]=3'b000) in a locked stream -> single errFlag pulse, errCount+1, lastErrPtr=34, locked stays 1.
- Nine corrupted filler words in one frame with the macro defined -> locked falls after the 8th error and errCount=9. Without the macro -> no errors and locked stays 1.
- Group counter: grpNum=3 at one word 149, then the same value received at the next word 149 -> no error. With grpNum=0, the next word 149 must be prev+1; sending prev instead -> one error.
- wordValid held 4 cycles at the same pointer with bad data -> exactly one error counted; reset asserted mid-frame -> all outputs 0, state HUNT.

Source files
------------

// File: rtl/m4_frame_checker.sv
// m4_frame_checker: M4 telemetry frame checker (lock FSM, counter/marker/filler checks); optional filler compare under M4CHK_FILLER_CHECK_EN
module m4_frame_checker #(
  parameter int LOCK_FRAMES = 2,
  parameter int UNLOCK_ERRS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wordValid,
  input  logic [8:0]  wordPtr,
  input  logic [11:0] wordData,
  input  logic [4:0]  grpNum,
  output logic        locked,
  output logic        errFlag,
  output logic [15:0] errCount,
  output logic [8:0]  lastErrPtr,
  output logic [9:0]  frameCnt,
  output logic [9:0]  grpCnt
);
  localparam int EW = $clog2(UNLOCK_ERRS + 1);
  localparam int GW = $clog2(LOCK_FRAMES + 1);
  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;
  state_t state, state_nx;
  logic          first;
  logic [8:0]    last_ptr;
  logic [9:0]    fr_prev, gr_prev;
  logic [7:0]    mk_prev;
  logic          fr_seed, gr_seed, mk_seed, gr_inc;
  logic [EW-1:0] pfe, pfe_base, pfe_nx;
  logic [GW-1:0] good;
  logic          acc, is_fr, is_gr, is_mk, hunt, frame_end, bad, bad_fr, bad_gr, bad_mk, bad_fl, err;
  logic [9:0]    fr_val, fr_exp, gr_exp;
  logic [7:0]    mk_val;
  // classify the accepted word and evaluate its format and sequence checks
  always_comb begin
    acc       = wordValid && (first || wordPtr != last_ptr);
    is_fr     = wordPtr == 9'd0;
    is_gr     = wordPtr == 9'd149;
    is_mk     = wordPtr[3:0] == 4'd2;
    hunt      = state == HUNT;
    frame_end = acc && is_fr;
    fr_val    = wordData[10:1];
    mk_val    = wordData[10:3];
    fr_exp    = fr_prev == 10'd500 ? 10'd0 : fr_prev + 10'd1;
    gr_exp    = gr_inc ? gr_prev + 10'd1 : gr_prev;
    bad_fr    = wordData[11] || !wordData[0] || (fr_seed && fr_val != fr_exp);
    bad_gr    = wordData[11] || wordData[0] || (gr_seed && fr_val != gr_exp);
    bad_mk    = wordData[11] || wordData[2:0] != 3'b001 || (mk_seed && mk_val != mk_prev + 8'd1);
`ifdef M4CHK_FILLER_CHECK_EN
    bad_fl    = wordData != 12'h002;
`else
    bad_fl    = 1'b0;
`endif
    bad       = is_fr ? bad_fr : is_gr ? bad_gr : is_mk ? bad_mk : bad_fl;
    err       = acc && !hunt && bad;
    pfe_base  = frame_end ? '0 : pfe;
    pfe_nx    = pfe_base + EW'(err && pfe_base != EW'(UNLOCK_ERRS));
  end
  // lock state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= HUNT;
    else state <= state_nx;
  // lock state transitions: hunt for word 0, verify clean frames, drop on error burst
  always_comb begin
    state_nx = state;
    case (state)
      HUNT:    state_nx = frame_end ? VERIFY : HUNT;
      VERIFY:  state_nx = frame_end && pfe == '0 && good == GW'(LOCK_FRAMES - 1) ? LOCKED : VERIFY;
      LOCKED:  state_nx = pfe >= EW'(UNLOCK_ERRS) ? HUNT : LOCKED;
      default: state_nx = HUNT;
    endcase
  end
  // lock status decode
  always_comb locked = state == LOCKED;
  // expected-base registers, error statistics and decoded counter outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      first      <= 1'b1;
      last_ptr   <= '0;
      fr_prev    <= '0;
      gr_prev    <= '0;
      mk_prev    <= '0;
      fr_seed    <= 1'b0;
      gr_seed    <= 1'b0;
      mk_seed    <= 1'b0;
      gr_inc     <= 1'b0;
      pfe        <= '0;
      good       <= '0;
      errFlag    <= 1'b0;
      errCount   <= '0;
      lastErrPtr <= '0;
      frameCnt   <= '0;
      grpCnt     <= '0;
    end else begin
      errFlag <= err;
      if (acc) begin
        first    <= 1'b0;
        last_ptr <= wordPtr;
      end
      if (acc && is_fr) frameCnt <= fr_val;
      if (acc && is_gr) grpCnt <= fr_val;
      if (err) begin
        errCount   <= errCount == 16'hFFFF ? errCount : errCount + 16'd1;
        lastErrPtr <= wordPtr;
      end
      if (hunt) begin
        fr_seed <= 1'b0;
        gr_seed <= 1'b0;
        mk_seed <= 1'b0;
        pfe     <= '0;
        good    <= '0;
        if (frame_end) begin
          fr_prev <= fr_val;
          fr_seed <= 1'b1;
        end
      end else begin
        pfe <= pfe_nx;
        if (acc && is_fr) begin
          fr_prev <= fr_val;
          fr_seed <= 1'b1;
        end
        if (acc && is_gr) begin
          gr_prev <= fr_val;
          gr_seed <= 1'b1;
          gr_inc  <= grpNum == 5'd0;
        end
        if (acc && !is_fr && !is_gr && is_mk) begin
          mk_prev <= mk_val;
          mk_seed <= 1'b1;
        end
        if (frame_end && state == VERIFY) good <= pfe == '0 ? good + GW'(1) : '0;
      end
    end
  end
endmodule
